line_buffer_ring: RTL and testbench

- Parametrised successor to the CGIA two-bank even/odd line buffer.
- Provides a ring of NBUF line buffers between the line producer (S side: fetch/sprite engine, write-only) and the display shifter (F side, read-only).
- Adds flow control, byte-lane writes, optional clear-on-read and sticky overrun/underrun status.
- Bank selection is tracked internally, so there is no external ODD select.

---
 rtl/cgia_lb_pkg.sv | 9 +
 rtl/lb_bank.sv | 21 ++
 rtl/line_buffer_ring.sv | 80 ++++++++
 tb/tb_line_buffer_ring.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cgia_lb_pkg.sv
// cgia_lb_pkg: shared defaults and bank-index width helper for the line buffer ring
package cgia_lb_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADR_W_DEF = 9;
  localparam logic [63:0] CLEAR_VAL_DEF = '0;
  function automatic int bank_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lb_bank.sv
// lb_bank: single-port read-first RAM with byte-lane writes
// Ports: CLK_I clock; adr word address; wdat write data; be byte-write enables;
// re read enable; rdat registered read data (old contents on a same-cycle write).
module lb_bank import cgia_lb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W = ADR_W_DEF
) (
  input  logic                CLK_I,
  input  logic [ADR_W-1:0]    adr,
  input  logic [DATA_W-1:0]   wdat,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  output logic [DATA_W-1:0]   rdat
);
  logic [DATA_W-1:0] mem [2**ADR_W];
  always_ff @(posedge CLK_I) begin
    if (re) rdat <= mem[adr];
    for (int i = 0; i < DATA_W/8; i++)
      if (be[i]) mem[adr][i*8 +: 8] <= wdat[i*8 +: 8];
  end
endmodule

// File: rtl/line_buffer_ring.sv
// line_buffer_ring: ring of NBUF line banks between a line producer and the display shifter
// Ports: CLK_I/RST_N_I clock and async active-low reset;
// S_* producer write port (address, data, byte lanes, strobe, line-done pulse, ready);
// F_* display read port (address, strobe, registered data, line-valid);
// SWAP_I retires the displayed line; ERR_CLR_I clears the sticky S_OVR_O / F_UND_O flags.
module line_buffer_ring import cgia_lb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W = ADR_W_DEF,
  parameter int NBUF = 2,
  parameter bit CLEAR_ON_READ = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = CLEAR_VAL_DEF[DATA_W-1:0]
) (
  input  logic                CLK_I,
  input  logic                RST_N_I,
  input  logic [ADR_W-1:0]    S_ADR_I,
  input  logic [DATA_W-1:0]   S_DAT_I,
  input  logic [DATA_W/8-1:0] S_SEL_I,
  input  logic                S_WE_I,
  input  logic                S_DONE_I,
  output logic                S_RDY_O,
  input  logic [ADR_W-1:0]    F_ADR_I,
  input  logic                F_RD_I,
  output logic [DATA_W-1:0]   F_DAT_O,
  output logic                F_VALID_O,
  input  logic                SWAP_I,
  input  logic                ERR_CLR_I,
  output logic                S_OVR_O,
  output logic                F_UND_O
);
  localparam int BW = bank_w(NBUF);
  localparam int CW = $clog2(NBUF + 1);
  logic [BW-1:0] wr_bank, rd_bank, rd_sel;
  logic [CW-1:0] count;
  logic have_dat, s_wr, f_rd, done_ok, swap_ok;
  logic [DATA_W-1:0] rdat [NBUF];
  assign S_RDY_O = count < CW'(NBUF);
  assign F_VALID_O = count != '0;
  assign s_wr = S_WE_I && S_RDY_O;
  assign f_rd = F_RD_I && F_VALID_O;
  assign done_ok = S_DONE_I && S_RDY_O;
  assign swap_ok = SWAP_I && F_VALID_O;
  // Banks hold their read register between reads, so muxing by the bank of the last
  // read gives a held output; have_dat forces zero until the first read after reset.
  assign F_DAT_O = have_dat ? rdat[rd_sel] : '0;
  always_ff @(posedge CLK_I or negedge RST_N_I)
    if (!RST_N_I) begin
      wr_bank <= '0;
      rd_bank <= '0;
      rd_sel <= '0;
      count <= '0;
      have_dat <= 1'b0;
      S_OVR_O <= 1'b0;
      F_UND_O <= 1'b0;
    end else begin
      if (done_ok) wr_bank <= wr_bank == BW'(NBUF - 1) ? '0 : wr_bank + 1'b1;
      if (swap_ok) rd_bank <= rd_bank == BW'(NBUF - 1) ? '0 : rd_bank + 1'b1;
      count <= count + CW'(done_ok) - CW'(swap_ok);
      if (f_rd) begin
        rd_sel <= rd_bank;
        have_dat <= 1'b1;
      end
      S_OVR_O <= ((S_WE_I || S_DONE_I) && !S_RDY_O) || (S_OVR_O && !ERR_CLR_I);
      F_UND_O <= ((F_RD_I || SWAP_I) && !F_VALID_O) || (F_UND_O && !ERR_CLR_I);
    end
  // wr_bank==rd_bank only when count is 0 or NBUF, where one side is blocked,
  // so a bank never sees both a producer write and a clear-on-read.
  for (genvar b = 0; b < NBUF; b++) begin : g_bank
    logic s_hit, f_hit;
    assign s_hit = s_wr && wr_bank == BW'(b);
    assign f_hit = f_rd && rd_bank == BW'(b);
    lb_bank #(.DATA_W(DATA_W), .ADR_W(ADR_W)) u_bank (
      .CLK_I(CLK_I),
      .adr(s_hit ? S_ADR_I : F_ADR_I),
      .wdat(s_hit ? S_DAT_I : CLEAR_VAL),
      .be(s_hit ? S_SEL_I : {(DATA_W/8){f_hit && CLEAR_ON_READ}}),
      .re(f_hit),
      .rdat(rdat[b])
    );
  end
endmodule

// File: tb/tb_line_buffer_ring.sv
// tb_line_buffer_ring: directed self-checking bench for line_buffer_ring (NBUF=3, clear-on-read)
module tb_line_buffer_ring;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [8:0] s_adr = '0, f_adr = '0;
  logic [15:0] s_dat = '0, f_dat;
  logic [1:0] s_sel = '0;
  logic s_we = 0, s_done = 0, s_rdy, f_rd = 0, f_valid, swap = 0, err_clr = 0, s_ovr, f_und;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  line_buffer_ring #(.DATA_W(16), .ADR_W(9), .NBUF(3), .CLEAR_ON_READ(1'b1), .CLEAR_VAL(16'h0000)) dut (
    .CLK_I(clk), .RST_N_I(rst_n),
    .S_ADR_I(s_adr), .S_DAT_I(s_dat), .S_SEL_I(s_sel), .S_WE_I(s_we), .S_DONE_I(s_done), .S_RDY_O(s_rdy),
    .F_ADR_I(f_adr), .F_RD_I(f_rd), .F_DAT_O(f_dat), .F_VALID_O(f_valid),
    .SWAP_I(swap), .ERR_CLR_I(err_clr), .S_OVR_O(s_ovr), .F_UND_O(f_und)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [8:0] a, input logic [15:0] d, input logic [1:0] sel);
    s_adr = a; s_dat = d; s_sel = sel; s_we = 1;
    tick;
    s_we = 0;
  endtask
  task automatic done;
    s_done = 1;
    tick;
    s_done = 0;
  endtask
  task automatic do_swap;
    swap = 1;
    tick;
    swap = 0;
  endtask
  task automatic rd(input logic [8:0] a);
    f_adr = a; f_rd = 1;
    tick;
    f_rd = 0;
  endtask
  task automatic test_reset;
    tick;
    rst_n = 1;
    tick;
    total++; if (s_rdy !== 1'b1 || f_valid !== 1'b0) begin bad++; $display("FAIL reset_flow rdy=%b valid=%b want 1 0", s_rdy, f_valid); end
    wr(3, 16'h1111, 2'b11);
    done;
    rd(3);
    total++; if (f_dat !== 16'h1111) begin bad++; $display("FAIL pre_reset_rd got=%h want=1111", f_dat); end
    #3 rst_n = 0;
    #1;
    total++; if (f_dat !== 16'h0000) begin bad++; $display("FAIL reset_fdat got=%h want=0000", f_dat); end
    total++; if (s_rdy !== 1'b1 || f_valid !== 1'b0) begin bad++; $display("FAIL reset_async rdy=%b valid=%b want 1 0", s_rdy, f_valid); end
    total++; if (s_ovr !== 1'b0 || f_und !== 1'b0) begin bad++; $display("FAIL reset_flags ovr=%b und=%b want 0 0", s_ovr, f_und); end
    tick;
    rst_n = 1;
    tick;
  endtask
  task automatic test_pingpong;
    wr(0, 16'hAAAA, 2'b11);
    done;
    wr(0, 16'h5555, 2'b11);
    done;
    rd(0);
    total++; if (f_dat !== 16'hAAAA) begin bad++; $display("FAIL pp_line0 got=%h want=aaaa", f_dat); end
    do_swap;
    rd(0);
    total++; if (f_dat !== 16'h5555) begin bad++; $display("FAIL pp_line1 got=%h want=5555", f_dat); end
    do_swap;
    total++; if (f_valid !== 1'b0 || s_rdy !== 1'b1) begin bad++; $display("FAIL pp_drained valid=%b rdy=%b want 0 1", f_valid, s_rdy); end
  endtask
  task automatic test_clear_lanes;
    wr(5, 16'h1234, 2'b11);
    done;
    rd(5);
    total++; if (f_dat !== 16'h1234) begin bad++; $display("FAIL clr_first got=%h want=1234", f_dat); end
    rd(5);
    total++; if (f_dat !== 16'h0000) begin bad++; $display("FAIL clr_second got=%h want=0000", f_dat); end
    wr(6, 16'h1234, 2'b11);
    wr(6, 16'hFFFF, 2'b01);
    done;
    do_swap;
    rd(6);
    total++; if (f_dat !== 16'h12FF) begin bad++; $display("FAIL byte_lane got=%h want=12ff", f_dat); end
    do_swap;
  endtask
  task automatic test_overrun;
    wr(0, 16'hCAFE, 2'b11);
    done;
    done;
    done;
    total++; if (s_rdy !== 1'b0 || f_valid !== 1'b1) begin bad++; $display("FAIL full rdy=%b valid=%b want 0 1", s_rdy, f_valid); end
    wr(0, 16'hBEEF, 2'b11);
    total++; if (s_ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", s_ovr); end
    rd(0);
    total++; if (f_dat !== 16'hCAFE) begin bad++; $display("FAIL ovr_nowrite got=%h want=cafe", f_dat); end
    do_swap;
    total++; if (s_rdy !== 1'b1 || s_ovr !== 1'b1) begin bad++; $display("FAIL after_swap rdy=%b ovr=%b want 1 1", s_rdy, s_ovr); end
    err_clr = 1;
    tick;
    err_clr = 0;
    total++; if (s_ovr !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%b want=0", s_ovr); end
    do_swap;
    do_swap;
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain valid=%b want 0", f_valid); end
  endtask
  task automatic test_back_to_back;
    wr(1, 16'h0101, 2'b11);
    done;
    for (int k = 0; k < 4; k++) begin
      wr(1, 16'hA000 + 16'(k), 2'b11);
      s_done = 1; swap = 1;
      tick;
      s_done = 0; swap = 0;
      total++; if (s_rdy !== 1'b1 || f_valid !== 1'b1) begin bad++; $display("FAIL b2b_flags%0d rdy=%b valid=%b want 1 1", k, s_rdy, f_valid); end
      rd(1);
      total++; if (f_dat !== 16'hA000 + 16'(k)) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", k, f_dat, 16'hA000 + 16'(k)); end
    end
    do_swap;
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL b2b_count valid=%b want 0", f_valid); end
  endtask
  task automatic test_underrun;
    do_swap;
    total++; if (f_und !== 1'b1) begin bad++; $display("FAIL und_swap got=%b want=1", f_und); end
    rd(1);
    total++; if (f_dat !== 16'hA003) begin bad++; $display("FAIL und_hold got=%h want=a003", f_dat); end
    f_rd = 1; err_clr = 1;
    tick;
    f_rd = 0; err_clr = 0;
    total++; if (f_und !== 1'b1) begin bad++; $display("FAIL und_wins got=%b want=1", f_und); end
    err_clr = 1;
    tick;
    err_clr = 0;
    total++; if (f_und !== 1'b0) begin bad++; $display("FAIL und_clr got=%b want=0", f_und); end
    wr(2, 16'h7777, 2'b11);
    done;
    rd(2);
    total++; if (f_dat !== 16'h7777) begin bad++; $display("FAIL und_ptrs got=%h want=7777", f_dat); end
  endtask
  initial begin
    test_reset;
    test_pingpong;
    test_clear_lanes;
    test_overrun;
    test_back_to_back;
    test_underrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
